// File: rtl/udp_tx_scheduler.sv
// Two-requester round-robin scheduler for a UDP/IP frame transmitter.
// Validates payload length, launches the transmitter, watches for completion and enforces the inter-frame gap.
module udp_tx_scheduler #(
  parameter int IFG_CYCLES     = 24,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MIN_LEN        = 18,
  parameter int MAX_LEN        = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic [1:0]  grant,
  output logic        ram_bank,
  output logic        tx_go,
  output logic [15:0] tx_total_length,
  output logic [15:0] tx_data_length,
  output logic [1:0]  ack,
  output logic [1:0]  drop,
  output logic        timeout_err,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state_dbg
);

  // Handshake: req[i] is a level held by requester i until it sees ack[i] or drop[i];
  // tx_go is a single-cycle launch accepted only while tx_busy is low, and tx_done closes it.

  localparam int WD_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);
  localparam logic [15:0]      MIN_L    = 16'(MIN_LEN);
  localparam logic [15:0]      MAX_L    = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t           state;
  logic             ptr;
  logic             winner;
  logic [15:0]      len_q;
  logic [WD_W-1:0]  wd_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic        sel;
  logic [15:0] sel_len;
  logic [1:0]  winner_oh;

  // Round-robin pick: the pointer requester if it asks, otherwise the other one.
  always_comb begin
    sel       = req[ptr] ? ptr : ~ptr;
    sel_len   = sel ? len1 : len0;
    winner_oh = winner ? 2'b10 : 2'b01;
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= 1'b0;
      winner          <= 1'b0;
      len_q           <= '0;
      wd_cnt          <= '0;
      gap_cnt         <= '0;
      grant           <= '0;
      ram_bank        <= 1'b0;
      tx_go           <= 1'b0;
      tx_total_length <= '0;
      tx_data_length  <= '0;
      ack             <= '0;
      drop            <= '0;
      timeout_err     <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      tx_go       <= 1'b0;
      ack         <= '0;
      drop        <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            winner <= sel;
            len_q  <= sel_len;
            state  <= CHECK;
          end
        end
        CHECK: begin
          ptr <= ~winner;
          if (len_q < MIN_L || len_q > MAX_L) begin
            drop  <= winner_oh;
            state <= IDLE;
          end else begin
            tx_data_length  <= len_q + 16'd8;
            tx_total_length <= len_q + 16'd28;
            grant           <= winner_oh;
            ram_bank        <= winner;
            state           <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!tx_busy) begin
            tx_go  <= 1'b1;
            wd_cnt <= '0;
            state  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (tx_done) begin
            ack       <= winner_oh;
            frame_cnt <= frame_cnt + 16'd1;
            grant     <= '0;
            gap_cnt   <= '0;
            state     <= (IFG_CYCLES == 0) ? IDLE : GAP;
          end else if (wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            drop        <= winner_oh;
            grant       <= '0;
            gap_cnt     <= '0;
            state       <= (IFG_CYCLES == 0) ? IDLE : GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
